// File: rtl/data_mem_if.sv
// Load/store bus between the core's memory stage (master) and data_mem (slave).
interface bus_if;
  logic        ren;
  logic        wen;
  logic [31:0] raddr;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  bytemask;
  logic [31:0] rdata;

  modport master (output ren, wen, raddr, waddr, wdata, bytemask, input rdata);
  modport slave  (input ren, wen, raddr, waddr, wdata, bytemask, output rdata);
endinterface

// File: rtl/data_mem.sv
// Data memory responder: word RAM with byte-masked writes plus an MMIO window
// holding a console TX FIFO, status register, cycle counter and halt register.
// Reads are registered (one cycle latency) and read-first against same-cycle writes.
module data_mem #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  bus_if.slave        bus,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned FW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] REG_TX     = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CYCLE  = 2'd2;
  localparam logic [1:0] REG_HALT   = 2'd3;

  // Merge the enabled byte lanes of new_w over old_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  logic [31:0]   ram [DEPTH_WORDS];

  logic [31:0]   rdata_q, rdata_d;
  logic [FW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [7:0]    fifo_d [FIFO_DEPTH];
  logic          ovf_q, ovf_d, err_q, err_d, halt_q, halt_d;
  logic [31:0]   halt_code_q, halt_code_d, cycle_q, cycle_d;

  // Address decode: the RAM base is aligned to its size, so the upper bits
  // identify a hit and the lower word bits index the array.
  logic          rd_ram, rd_mmio, wr_ram, wr_mmio;
  logic [AW-1:0] ridx, widx;
  logic [1:0]    rd_sel, wr_sel;
  logic          unused_addr_bits;

  assign rd_ram  = bus.raddr[31:AW+2] == RAM_BASE[31:AW+2];
  assign wr_ram  = bus.waddr[31:AW+2] == RAM_BASE[31:AW+2];
  assign rd_mmio = bus.raddr[31:4] == MMIO_BASE[31:4];
  assign wr_mmio = bus.waddr[31:4] == MMIO_BASE[31:4];
  assign ridx    = bus.raddr[AW+1:2];
  assign widx    = bus.waddr[AW+1:2];
  assign rd_sel  = bus.raddr[3:2];
  assign wr_sel  = bus.waddr[3:2];
  assign unused_addr_bits = ^{bus.raddr[1:0], bus.waddr[1:0]};

  logic ram_we, mmio_we, rd_err, wr_err;
  logic empty, full, pop, push_req, push, status_wr, halt_wr;
  logic [31:0] status;

  assign ram_we    = bus.wen && wr_ram;
  assign mmio_we   = bus.wen && !wr_ram && wr_mmio;
  assign rd_err    = bus.ren && !rd_ram && !rd_mmio;
  assign wr_err    = bus.wen && !wr_ram && !wr_mmio;

  assign empty     = wr_ptr_q == rd_ptr_q;
  assign full      = (wr_ptr_q[FW] != rd_ptr_q[FW]) &&
                     (wr_ptr_q[FW-1:0] == rd_ptr_q[FW-1:0]);
  assign pop       = !empty && tx_ready;
  assign push_req  = mmio_we && (wr_sel == REG_TX) && bus.bytemask[0];
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push      = push_req && (!full || pop);
  assign status_wr = mmio_we && (wr_sel == REG_STATUS) && bus.bytemask[0];
  assign halt_wr   = mmio_we && (wr_sel == REG_HALT) && (bus.bytemask != 4'b0000);
  assign status    = {28'b0, err_q, ovf_q, full, empty};

  // Read path: select the addressed word from pre-edge state; hold when idle.
  // NOTE: combinational blocks use blocking '=' with a default first so no latch
  // is inferred; clocked blocks use non-blocking '<=' so all flops update together.
  always_comb begin
    rdata_d = rdata_q;
    if (bus.ren) begin
      if (rd_ram) begin
        rdata_d = ram[ridx];
      end else if (rd_mmio) begin
        case (rd_sel)
          REG_TX:     rdata_d = '0;
          REG_STATUS: rdata_d = status;
          REG_CYCLE:  rdata_d = cycle_q;
          default:    rdata_d = halt_code_q;
        endcase
      end else begin
        rdata_d = '0;
      end
    end
  end

  // MMIO state: FIFO push/pop, sticky status flags, halt capture, cycle counter.
  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q[FW-1:0]] = bus.wdata[7:0];
    wr_ptr_d = wr_ptr_q + (FW+1)'(push);
    rd_ptr_d = rd_ptr_q + (FW+1)'(pop);

    // A new event wins over a same-cycle write-1-to-clear so it is never lost.
    ovf_d = (push_req && full && !pop) || (ovf_q && !(status_wr && bus.wdata[2]));
    err_d = rd_err || wr_err || (err_q && !(status_wr && bus.wdata[3]));

    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    if (halt_wr && !halt_q) begin
      halt_d      = 1'b1;
      halt_code_d = merge_bytes(halt_code_q, bus.wdata, bus.bytemask);
    end

    cycle_d = cycle_q + 32'd1;
  end

  // RAM write port; a request coinciding with reset is discarded.
  // NOTE: the RAM array is deliberately not reset so it can map onto block RAM;
  // only the control/MMIO state below is cleared by rst.
  always_ff @(posedge clk) begin
    if (!rst && ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.bytemask[i]) ram[widx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  // Control and MMIO registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_q      <= '{default: '0};
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
      cycle_q     <= '0;
    end else begin
      rdata_q     <= rdata_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_q      <= fifo_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
      cycle_q     <= cycle_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign tx_valid  = !empty;
  assign tx_data   = empty ? 8'h00 : fifo_q[rd_ptr_q[FW-1:0]];
  assign halt      = halt_q;
  assign halt_code = halt_code_q;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed scenarios plus randomized traffic,
// all compared against a transaction-level reference model.
module tb_data_mem;

  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] MMIO  = 32'h8000_0000;
  localparam logic [31:0] A_TX  = MMIO + 32'h0;
  localparam logic [31:0] A_ST  = MMIO + 32'h4;
  localparam logic [31:0] A_CYC = MMIO + 32'h8;
  localparam logic [31:0] A_HLT = MMIO + 32'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        halt;
  logic [31:0] halt_code;

  bus_if bus_m ();

  data_mem #(
    .DEPTH_WORDS(DEPTH),
    .RAM_BASE   (32'h0000_0000),
    .MMIO_BASE  (MMIO),
    .FIFO_DEPTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_m),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .halt     (halt),
    .halt_code(halt_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [31:0] m_ram [int];
  byte unsigned m_fifo [$];
  logic        m_ovf, m_err, m_halt;
  logic [31:0] m_code, m_cycle, m_rdata;

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // One clock: the model consumes the request at the edge, outputs are compared mid-cycle.
  task automatic step();
    logic [31:0] ra, wa;
    logic set_ovf, set_err, clr_ovf, clr_err, pop;
    @(posedge clk);
    if (rst) begin
      m_fifo.delete();
      m_ovf = 1'b0; m_err = 1'b0; m_halt = 1'b0;
      m_code = '0; m_cycle = '0; m_rdata = '0;
    end else begin
      ra = {bus_m.raddr[31:2], 2'b00};
      wa = {bus_m.waddr[31:2], 2'b00};
      set_ovf = 1'b0; set_err = 1'b0; clr_ovf = 1'b0; clr_err = 1'b0;
      pop = tx_ready && (m_fifo.size() != 0);
      if (bus_m.ren) begin
        if (ra < 4 * DEPTH) m_rdata = m_ram[int'(ra >> 2)];
        else if (ra >= MMIO && ra < MMIO + 16) begin
          case (ra - MMIO)
            32'h0:   m_rdata = '0;
            32'h4:   m_rdata = {28'b0, m_err, m_ovf, m_fifo.size() == 8, m_fifo.size() == 0};
            32'h8:   m_rdata = m_cycle;
            default: m_rdata = m_code;
          endcase
        end else begin
          m_rdata = '0;
          set_err = 1'b1;
        end
      end
      if (pop) void'(m_fifo.pop_front());
      if (bus_m.wen) begin
        if (wa < 4 * DEPTH) begin
          m_ram[int'(wa >> 2)] = lane_merge(m_ram[int'(wa >> 2)], bus_m.wdata, bus_m.bytemask);
        end else if (wa >= MMIO && wa < MMIO + 16) begin
          case (wa - MMIO)
            32'h0: if (bus_m.bytemask[0]) begin
              if (m_fifo.size() < 8) m_fifo.push_back(bus_m.wdata[7:0]);
              else set_ovf = 1'b1;
            end
            32'h4: if (bus_m.bytemask[0]) begin
              clr_ovf = bus_m.wdata[2];
              clr_err = bus_m.wdata[3];
            end
            32'h8: ;
            default: if (bus_m.bytemask != 4'b0 && !m_halt) begin
              m_halt = 1'b1;
              m_code = lane_merge(m_code, bus_m.wdata, bus_m.bytemask);
            end
          endcase
        end else begin
          set_err = 1'b1;
        end
      end
      m_ovf   = set_ovf || (m_ovf && !clr_ovf);
      m_err   = set_err || (m_err && !clr_err);
      m_cycle = m_cycle + 32'd1;
    end
    @(negedge clk);
    check("rdata", bus_m.rdata, m_rdata);
    check("tx_valid", 32'(tx_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) check("tx_data", 32'(tx_data), 32'(m_fifo[0]));
    check("halt", 32'(halt), 32'(m_halt));
    check("halt_code", halt_code, m_code);
  endtask

  task automatic bus_op(input logic r, input logic [31:0] ra, input logic w,
                        input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] m);
    bus_m.ren = r; bus_m.raddr = ra;
    bus_m.wen = w; bus_m.waddr = wa; bus_m.wdata = wd; bus_m.bytemask = m;
    step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bus_op(1'b0, '0, 1'b1, a, d, m);
  endtask

  task automatic rd(input logic [31:0] a);
    bus_op(1'b1, a, 1'b0, '0, '0, 4'h0);
  endtask

  task automatic idle();
    bus_op(1'b0, '0, 1'b0, '0, '0, 4'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    int s;
    s = $urandom_range(0, 9);
    if (s <= 4)      a = 4 * $urandom_range(0, 63);
    else if (s == 5) a = 4 * (DEPTH - 1);
    else if (s <= 8) a = MMIO + 4 * $urandom_range(0, 3);
    else begin
      case ($urandom_range(0, 3))
        0:       a = 4 * DEPTH;
        1:       a = MMIO + 32'h10;
        2:       a = 32'h4000_0000;
        default: a = MMIO - 32'h4;
      endcase
    end
    a[1:0] = 2'($urandom_range(0, 3));
    return a;
  endfunction

  initial begin
    rst = 1'b1;
    tx_ready = 1'b0;
    bus_m.ren = 1'b0; bus_m.wen = 1'b0; bus_m.raddr = '0; bus_m.waddr = '0;
    bus_m.wdata = '0; bus_m.bytemask = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state.
    check("rst_rdata", bus_m.rdata, 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_halt_code", halt_code, 32'h0);
    rd(A_ST);
    check("rst_status", bus_m.rdata, 32'h1);

    // Seed the RAM words used by the random phase.
    for (int i = 0; i < 64; i++) wr(32'(4 * i), $urandom, 4'hF);
    wr(32'(4 * (DEPTH - 1)), $urandom, 4'hF);

    // Byte-masked write merge.
    wr(32'h100, 32'hDEAD_BEEF, 4'hF);
    wr(32'h100, 32'h0000_5500, 4'h2);
    rd(32'h100);
    check("mask_merge", bus_m.rdata, 32'hDEAD_55EF);

    // Read-first on simultaneous read/write of the same word.
    wr(32'h104, 32'hCAFE_F00D, 4'hF);
    bus_op(1'b1, 32'h104, 1'b1, 32'h104, 32'h1234_5678, 4'hF);
    check("read_first", bus_m.rdata, 32'hCAFE_F00D);
    rd(32'h104);
    check("after_write", bus_m.rdata, 32'h1234_5678);

    // FIFO fill, overflow, drain, clear.
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(A_TX, 32'h41 + 32'(i), 4'h1);
    rd(A_ST);
    check("status_full_ovf", bus_m.rdata, 32'h6);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 32'(tx_valid), 32'h1);
      check("drain_data", 32'(tx_data), 32'h41 + 32'(i));
      idle();
    end
    check("drain_done", 32'(tx_valid), 32'h0);
    wr(A_ST, 32'h4, 4'h1);
    rd(A_ST);
    check("ovf_cleared", bus_m.rdata, 32'h1);

    // Cycle counter from reset release, then wrap.
    do_reset();
    rd(A_CYC);
    check("cycle_0", bus_m.rdata, 32'd0);
    for (int i = 0; i < 9; i++) idle();
    rd(A_CYC);
    check("cycle_10", bus_m.rdata, 32'd10);
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    m_cycle = 32'hFFFF_FFFF;
    idle();
    rd(A_CYC);
    check("cycle_wrap", bus_m.rdata, 32'h0);

    // Halt capture is sticky until reset.
    wr(A_HLT, 32'h1, 4'hF);
    wr(A_HLT, 32'h2, 4'hF);
    check("halt_set", 32'(halt), 32'h1);
    check("halt_code_first", halt_code, 32'h1);
    rd(A_HLT);
    check("halt_readback", bus_m.rdata, 32'h1);
    do_reset();
    check("halt_cleared", 32'(halt), 32'h0);
    check("halt_code_cleared", halt_code, 32'h0);

    // Unmapped read sets err; write-1 clears it.
    rd(32'h4000_0000);
    check("unmapped_rdata", bus_m.rdata, 32'h0);
    rd(A_ST);
    check("err_set", bus_m.rdata, 32'h9);
    wr(A_ST, 32'h8, 4'h1);
    rd(A_ST);
    check("err_cleared", bus_m.rdata, 32'h1);

    // Reset mid-traffic: FIFO flushed with tx_ready low, request at that edge dropped.
    tx_ready = 1'b0;
    wr(32'h8, 32'h1111_1111, 4'hF);
    for (int i = 0; i < 3; i++) wr(A_TX, 32'h60 + 32'(i), 4'h1);
    rst = 1'b1;
    bus_op(1'b1, 32'h8, 1'b1, 32'h8, 32'h2222_2222, 4'hF);
    rst = 1'b0;
    check("flush_tx_valid", 32'(tx_valid), 32'h0);
    rd(32'h8);
    check("rst_write_dropped", bus_m.rdata, 32'h1111_1111);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      tx_ready = 1'($urandom_range(0, 1));
      bus_op(1'($urandom_range(0, 1)), pick_addr(),
             1'($urandom_range(0, 2) != 0), pick_addr(), $urandom,
             4'($urandom_range(0, 15)));
      if (n == 1000) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
